// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
//   Data-memory controller between the EX/MEM register and a 16-bit async SRAM.
//   A 32-bit load/store is split into a low-halfword phase (LO) and a
//   high-halfword phase (HI), each held on the SRAM pins for WAIT_CYCLES
//   cycles, followed by a single DONE cycle. freeze stalls the pipeline while
//   an access is pending.
// Ports
//   clk, rst          pipeline clock (rising edge), async active-low reset
//   mem_r_en/mem_w_en load / store request (both set -> store)
//   address           byte address; word = (address - BASE_ADDR) >> 2
//   write_data        store data
//   read_data         load result, valid while ready=1 in DONE, held after
//   ready/freeze      ready = (IDLE & ~req) | DONE, freeze = ~ready
//   sram_addr/wdata   halfword address and write data (hold when idle)
//   sram_rdata        halfword read data from the SRAM
//   sram_we_n/oe_n    active-low strobes, asserted only in LO/HI
module sram_access_ctrl #(
    parameter int          WAIT_CYCLES   = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int          SRAM_ADDR_LEN = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_r_en,
    input  logic                     mem_w_en,
    input  logic [31:0]              address,
    input  logic [31:0]              write_data,
    output logic [31:0]              read_data,
    output logic                     ready,
    output logic                     freeze,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [15:0]              sram_wdata,
    input  logic [15:0]              sram_rdata,
    output logic                     sram_we_n,
    output logic                     sram_oe_n
);

    localparam int WW = SRAM_ADDR_LEN - 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t                   r_state, w_next_state;
    logic [CW-1:0]            r_cnt;
    logic                     r_wr;
    logic [WW-1:0]            r_word;
    logic [15:0]              r_wdata_hi;
    logic [31:0]              r_rdata;
    logic [SRAM_ADDR_LEN-1:0] r_sram_addr;
    logic [15:0]              r_sram_wdata;

    logic                     w_req;
    logic                     w_last;
    logic                     w_active;
    logic [WW-1:0]            w_word;

    assign w_req  = mem_r_en | mem_w_en;
    // Wraps modulo 2^32 and is truncated to the SRAM word width; no range check.
    assign w_word = WW'((address - BASE_ADDR) >> 2);
    assign w_last = (r_cnt == CW'(WAIT_CYCLES - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req)  w_next_state = S_LO;
            S_LO:    if (w_last) w_next_state = S_HI;
            S_HI:    if (w_last) w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_wr         <= 1'b0;
            r_word       <= '0;
            r_wdata_hi   <= '0;
            r_rdata      <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_LO) || (r_state == S_HI))
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            else
                r_cnt <= '0;

            case (r_state)
                S_IDLE: if (w_req) begin
                    r_wr         <= mem_w_en;   // r&w together is a store
                    r_word       <= w_word;
                    r_wdata_hi   <= write_data[31:16];
                    r_sram_addr  <= {w_word, 1'b0};
                    r_sram_wdata <= write_data[15:0];
                end
                S_LO: if (w_last) begin
                    // Switch the pins to the high halfword as LO ends.
                    r_sram_addr  <= {r_word, 1'b1};
                    r_sram_wdata <= r_wdata_hi;
                    if (!r_wr) r_rdata[15:0] <= sram_rdata;
                end
                S_HI: if (w_last && !r_wr) r_rdata[31:16] <= sram_rdata;
                default: ;
            endcase
        end
    end

    // Strobes are decoded from state so an async reset drops them at once.
    assign w_active   = (r_state == S_LO) || (r_state == S_HI);
    assign sram_we_n  = ~(w_active & r_wr);
    assign sram_oe_n  = ~(w_active & ~r_wr);
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;
    assign read_data  = r_rdata;
    assign ready      = ((r_state == S_IDLE) & ~w_req) | (r_state == S_DONE);
    assign freeze     = ~ready;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl (W=2, BASE=1024) with a behavioural
// SRAM. Expected per-cycle pin states are queued when a request is driven
// and popped/compared once per cycle on the falling edge.
module tb_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_we_n, sram_oe_n;

    sram_access_ctrl dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .freeze(freeze), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: async read, write on clock edge while we_n is low.
    logic [15:0] mem [0:1023];
    logic        pre_en = 1'b0;
    logic [9:0]  pre_a  = '0;
    logic [15:0] pre_d  = '0;
    always @(posedge clk) begin
        if (pre_en)          mem[pre_a] <= pre_d;
        else if (!sram_we_n) mem[sram_addr[9:0]] <= sram_wdata;
    end
    assign sram_rdata = mem[sram_addr[9:0]];

    typedef struct {
        logic        rdy, we_n, oe_n;
        logic        ca;  logic [17:0] a;
        logic        cw;  logic [15:0] w;
        logic        cr;  logic [31:0] rd;
    } snap_t;

    snap_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    string cur = "";
    logic [31:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s/%s: observed %h expected %h", cur, tag, obs, exp);
        end
    endtask

    task automatic push(input logic rdy, we_n, oe_n, ca, input logic [17:0] a,
                        input logic cw, input logic [15:0] w, input logic cr,
                        input logic [31:0] rd);
        snap_t s;
        s.rdy = rdy; s.we_n = we_n; s.oe_n = oe_n;
        s.ca = ca; s.a = a; s.cw = cw; s.w = w; s.cr = cr; s.rd = rd;
        sb.push_back(s);
    endtask

    // Full W=2 access starting in its request cycle T: T, LO x2, HI x2, DONE.
    task automatic exp_access(input logic wr, input logic [16:0] word,
                              input logic [31:0] wd, input logic [31:0] rd_done);
        push(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 2; i++)
            push(1'b0, ~wr, wr, 1'b1, {word, 1'b0}, wr, wd[15:0], 1'b0, '0);
        for (int i = 0; i < 2; i++)
            push(1'b0, ~wr, wr, 1'b1, {word, 1'b1}, wr, wd[31:16], 1'b0, '0);
        push(1'b1, 1'b1, 1'b1, 1'b1, {word, 1'b1}, 1'b0, '0, 1'b1, rd_done);
    endtask

    // Compare one cycle on the falling edge, then move to just after the next rising edge.
    task automatic step();
        snap_t s;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            s = sb.pop_front();
            chk("ready",  {31'd0, ready},     {31'd0, s.rdy});
            chk("freeze", {31'd0, freeze},    {31'd0, ~s.rdy});
            chk("we_n",   {31'd0, sram_we_n}, {31'd0, s.we_n});
            chk("oe_n",   {31'd0, sram_oe_n}, {31'd0, s.oe_n});
            if (s.ca) chk("sram_addr",  {14'd0, sram_addr},  {14'd0, s.a});
            if (s.cw) chk("sram_wdata", {16'd0, sram_wdata}, {16'd0, s.w});
            if (s.cr) chk("read_data",  read_data, s.rd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic r, w, input logic [31:0] a, d);
        mem_r_en = r; mem_w_en = w; address = a; write_data = d;
    endtask

    initial begin
        // Reset state
        cur = "reset";
        #12;
        chk("ready",      {31'd0, ready},     32'd1);
        chk("freeze",     {31'd0, freeze},    32'd0);
        chk("we_n",       {31'd0, sram_we_n}, 32'd1);
        chk("oe_n",       {31'd0, sram_oe_n}, 32'd1);
        chk("sram_addr",  {14'd0, sram_addr}, 32'd0);
        chk("sram_wdata", {16'd0, sram_wdata}, 32'd0);
        chk("read_data",  read_data,          32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // 1: idle for 20 cycles; preload SRAM words 2/3 on the way
        cur = "idle";
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin pre_en = 1'b1; pre_a = 10'd2; pre_d = 16'h5678; end
            if (i == 1) begin pre_a = 10'd3; pre_d = 16'h1234; end
            if (i == 2) pre_en = 1'b0;
            push(1'b1, 1'b1, 1'b1, 1'b1, '0, 1'b1, '0, 1'b1, 32'd0);
            step();
        end

        // 2: store 0xDEADBEEF to 1024
        cur = "store";
        req(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        exp_access(1'b1, 17'd0, 32'hDEADBEEF, exp_rd);
        step();
        req(1'b0, 1'b0, '0, '0);
        repeat (5) step();

        // 3: load from 1028 -> SRAM words 2,3
        cur = "load";
        req(1'b1, 1'b0, 32'd1028, 32'h0);
        exp_rd = 32'h12345678;
        exp_access(1'b0, 17'd1, 32'h0, exp_rd);
        step();
        req(1'b0, 1'b0, '0, '0);
        repeat (5) step();

        // 4: back-to-back store then load to 1040
        cur = "b2b";
        req(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
        exp_access(1'b1, 17'd4, 32'hCAFEF00D, exp_rd);
        repeat (5) step();
        req(1'b1, 1'b0, 32'd1040, 32'h0);   // presented while DONE
        step();                              // DONE cycle (ready=1)
        exp_rd = 32'hCAFEF00D;
        exp_access(1'b0, 17'd4, 32'h0, exp_rd);
        step();                              // IDLE capture cycle, freeze=1
        req(1'b0, 1'b0, '0, '0);
        repeat (5) step();
        push(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1, exp_rd);
        step();

        // 5: reset in the first HI cycle of a store
        cur = "rst_mid";
        req(1'b0, 1'b1, 32'd1048, 32'h11112222);
        push(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        push(1'b0, 1'b0, 1'b1, 1'b1, 18'd12, 1'b1, 16'h2222, 1'b0, '0);
        push(1'b0, 1'b0, 1'b1, 1'b1, 18'd12, 1'b1, 16'h2222, 1'b0, '0);
        step();
        req(1'b0, 1'b0, '0, '0);
        repeat (2) step();
        chk("hi_we_n", {31'd0, sram_we_n}, 32'd0);
        chk("hi_addr", {14'd0, sram_addr}, 32'd13);
        #2 rst = 1'b0;
        #1;
        chk("async_we_n",  {31'd0, sram_we_n}, 32'd1);
        chk("async_oe_n",  {31'd0, sram_oe_n}, 32'd1);
        chk("async_ready", {31'd0, ready},     32'd1);
        chk("async_addr",  {14'd0, sram_addr}, 32'd0);
        chk("async_rd",    read_data,          32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        cur = "post_rst_load";
        req(1'b1, 1'b0, 32'd1040, 32'h0);
        exp_rd = 32'hCAFEF00D;
        exp_access(1'b0, 17'd4, 32'h0, exp_rd);
        step();
        req(1'b0, 1'b0, '0, '0);
        repeat (5) step();

        // 6: r and w both set -> store, read_data untouched
        cur = "rw_both";
        req(1'b1, 1'b1, 32'd1056, 32'hA5A50F0F);
        exp_access(1'b1, 17'd8, 32'hA5A50F0F, exp_rd);
        step();
        req(1'b0, 1'b0, '0, '0);
        repeat (5) step();
        cur = "rw_readback";
        req(1'b1, 1'b0, 32'd1056, 32'h0);
        exp_rd = 32'hA5A50F0F;
        exp_access(1'b0, 17'd8, 32'h0, exp_rd);
        step();
        req(1'b0, 1'b0, '0, '0);
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
